// File: rtl/bk_sector_seq_if.sv
// rtl/bk_sector_seq_if.sv - hps_io SD block request/ack bundle for the sector sequencer
interface bk_sector_seq_if #(
   parameter int LBA_W = 32
);
   logic [LBA_W-1:0] sd_lba;
   logic             sd_rd;
   logic             sd_wr;
   logic             sd_ack;

   modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
   modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);
endinterface

// File: rtl/bk_sector_seq.sv
// rtl/bk_sector_seq.sv - save-state slot load/save sector sequencer over hps_io SD blocks
// Optional ack watchdog with sticky error enabled by BK_TIMEOUT_EN.
module bk_sector_seq #(
   parameter int SLOT_BITS = 2,
   parameter int SECT_BITS = 6,
   parameter int LBA_W     = 32,
   parameter int TIMEOUT_W = 24
) (
   input  logic                 clk_sys,
   input  logic                 RESET_n,
   input  logic                 enable,
   input  logic                 load_req,
   input  logic                 save_req,
   input  logic                 abort,
   input  logic [SLOT_BITS-1:0] slot,
   bk_sector_seq_if.master      sd,
   output logic                 busy,
   output logic                 loading,
   output logic [SECT_BITS-1:0] sect_idx,
   output logic                 done,
   output logic                 error
);

   typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

   state_t state;
   logic   ld_q, sv_q, ack_q, abort_seen;
   logic   ld_lvl, sv_lvl, start_ld, start_sv, ack_rise, ack_fall;

   assign ld_lvl   = load_req & enable;
   assign sv_lvl   = save_req & enable;
   assign start_ld = ld_lvl & ~ld_q;
   assign start_sv = sv_lvl & ~sv_q;
   assign ack_rise = sd.sd_ack & ~ack_q;
   assign ack_fall = ~sd.sd_ack & ack_q;

`ifdef BK_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] tmo_cnt;
   logic [TIMEOUT_W-1:0] tmo_nxt;
   assign tmo_nxt = tmo_cnt + TIMEOUT_W'(1);
`else
   assign error = |TIMEOUT_W'(0);
`endif

   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         state      <= IDLE;
         ld_q       <= 1'b0;
         sv_q       <= 1'b0;
         ack_q      <= 1'b0;
         abort_seen <= 1'b0;
         sd.sd_lba  <= '0;
         sd.sd_rd   <= 1'b0;
         sd.sd_wr   <= 1'b0;
         busy       <= 1'b0;
         loading    <= 1'b0;
         sect_idx   <= '0;
         done       <= 1'b0;
`ifdef BK_TIMEOUT_EN
         tmo_cnt    <= '0;
         error      <= 1'b0;
`endif
      end else begin
         // Edge registers run in every state so starts seen while busy are consumed.
         ld_q  <= ld_lvl;
         sv_q  <= sv_lvl;
         ack_q <= sd.sd_ack;
         done  <= 1'b0;

         case (state)
            IDLE: begin
               if (start_ld || start_sv) begin
                  state      <= REQ;
                  busy       <= 1'b1;
                  loading    <= start_ld;
                  sd.sd_rd   <= start_ld;
                  sd.sd_wr   <= ~start_ld;
                  sd.sd_lba  <= LBA_W'({slot, {SECT_BITS{1'b0}}});
                  sect_idx   <= '0;
                  abort_seen <= 1'b0;
`ifdef BK_TIMEOUT_EN
                  tmo_cnt    <= '0;
                  error      <= 1'b0;
`endif
               end
            end

            REQ: begin
               if (ack_rise) begin
                  sd.sd_rd   <= 1'b0;
                  sd.sd_wr   <= 1'b0;
                  abort_seen <= abort;
                  state      <= XFER;
               end else if (abort) begin
                  sd.sd_rd <= 1'b0;
                  sd.sd_wr <= 1'b0;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  loading  <= 1'b0;
                  state    <= IDLE;
               end
            end

            XFER: begin
               if (ack_fall) begin
                  if ((&sect_idx) || abort_seen || abort) begin
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     loading <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     sd.sd_lba  <= sd.sd_lba + LBA_W'(1);
                     sect_idx   <= sect_idx + SECT_BITS'(1);
                     sd.sd_rd   <= loading;
                     sd.sd_wr   <= ~loading;
                     abort_seen <= 1'b0;
                     state      <= REQ;
                  end
               end else begin
                  abort_seen <= abort_seen | abort;
               end
            end

            default: state <= IDLE;
         endcase

`ifdef BK_TIMEOUT_EN
         // Watchdog overrides whatever the state logic chose this cycle.
         if (state != IDLE) begin
            if (ack_rise || ack_fall) begin
               tmo_cnt <= '0;
            end else if (&tmo_nxt) begin
               tmo_cnt  <= '0;
               error    <= 1'b1;
               sd.sd_rd <= 1'b0;
               sd.sd_wr <= 1'b0;
               done     <= 1'b1;
               busy     <= 1'b0;
               loading  <= 1'b0;
               state    <= IDLE;
            end else begin
               tmo_cnt <= tmo_nxt;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_bk_sector_seq.sv
// tb/tb_bk_sector_seq.sv - directed bench for bk_sector_seq (default and 4-sector/4-bit-timeout instances)
module tb_bk_sector_seq;

   logic       clk_sys = 1'b0;
   logic       rst_n;
   logic       enable_a, enable_b, load_req, save_req, abort;
   logic [1:0] slot;
   logic       busy_a, loading_a, done_a, error_a;
   logic       busy_b, loading_b, done_b, error_b;
   logic [5:0] sect_a;
   logic [1:0] sect_b;

   int vectors = 0;
   int miscompares = 0;
   int done_cnt_a, done_cnt_b, wr_seen_a, notload_a, reqs_a;

   bk_sector_seq_if #(.LBA_W(32)) if_a ();
   bk_sector_seq_if #(.LBA_W(32)) if_b ();

   bk_sector_seq u_dut_a (
      .clk_sys (clk_sys), .RESET_n (rst_n), .enable (enable_a),
      .load_req (load_req), .save_req (save_req), .abort (abort), .slot (slot),
      .sd (if_a), .busy (busy_a), .loading (loading_a), .sect_idx (sect_a),
      .done (done_a), .error (error_a)
   );

   bk_sector_seq #(.SECT_BITS(2), .TIMEOUT_W(4)) u_dut_b (
      .clk_sys (clk_sys), .RESET_n (rst_n), .enable (enable_b),
      .load_req (load_req), .save_req (save_req), .abort (abort), .slot (slot),
      .sd (if_b), .busy (busy_b), .loading (loading_b), .sect_idx (sect_b),
      .done (done_b), .error (error_b)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_sys);
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
      if (if_a.sd_wr) wr_seen_a++;
      if (busy_a && !loading_a) notload_a++;
      if (if_a.sd_rd || if_a.sd_wr) reqs_a++;
   endtask

   function automatic logic req_of(input bit b);
      return b ? (if_b.sd_rd | if_b.sd_wr) : (if_a.sd_rd | if_a.sd_wr);
   endfunction

   task automatic set_ack(input bit b, input logic v);
      if (b) if_b.sd_ack = v;
      else   if_a.sd_ack = v;
   endtask

   task automatic clear_counts();
      done_cnt_a = 0; done_cnt_b = 0; wr_seen_a = 0; notload_a = 0; reqs_a = 0;
   endtask

   // Hold ack high for hi cycles; optionally pulse abort mid-sector.
   task automatic serve(input bit b, input logic [31:0] lba_exp, input int idx_exp,
                        input int hi, input bit ab);
      int t;
      t = 0;
      while (!req_of(b) && t < 40) begin
         step();
         t++;
      end
      chk("req_wait", 32'(t < 40), 1);
      chk("lba", b ? if_b.sd_lba : if_a.sd_lba, lba_exp);
      chk("sect_idx", b ? 32'(sect_b) : 32'(sect_a), idx_exp);
      set_ack(b, 1'b1);
      step();
      chk("req_drop_on_ack", 32'(req_of(b)), 0);
      for (int i = 1; i < hi; i++) begin
         abort = ab && (i == hi / 2);
         step();
      end
      abort = 1'b0;
      set_ack(b, 1'b0);
      step();
   endtask

   initial begin
      int t;
      rst_n = 1'b0; enable_a = 1'b0; enable_b = 1'b0;
      load_req = 1'b0; save_req = 1'b0; abort = 1'b0; slot = 2'd0;
      if_a.sd_ack = 1'b0; if_b.sd_ack = 1'b0;
      clear_counts();
      step(); step();
      chk("rst_lba", if_a.sd_lba, 0);
      chk("rst_rd", 32'(if_a.sd_rd), 0);
      chk("rst_wr", 32'(if_a.sd_wr), 0);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_loading", 32'(loading_a), 0);
      chk("rst_sect", 32'(sect_a), 0);
      chk("rst_done", 32'(done_a), 0);
      chk("rst_error", 32'(error_a), 0);
      rst_n = 1'b1;
      step();

      // Full 64-sector load from slot 2
      clear_counts();
      slot = 2'd2; enable_a = 1'b1; load_req = 1'b1;
      step();
      chk("load_rd_latency", 32'(if_a.sd_rd), 1);
      chk("load_busy", 32'(busy_a), 1);
      chk("load_loading", 32'(loading_a), 1);
      for (int s = 0; s < 64; s++) serve(1'b0, 32'(128 + s), s, 10, 1'b0);
      chk("load_done_pulse", 32'(done_a), 1);
      step();
      chk("load_busy_after", 32'(busy_a), 0);
      chk("load_done_count", done_cnt_a, 1);
      chk("load_no_wr", wr_seen_a, 0);
      chk("load_loading_held", notload_a, 0);
      load_req = 1'b0; enable_a = 1'b0;
      step();

      // Save of 4-sector slot 0 on the small instance
      clear_counts();
      slot = 2'd0; enable_b = 1'b1; save_req = 1'b1;
      step();
      chk("save_wr_latency", 32'(if_b.sd_wr), 1);
      chk("save_no_rd", 32'(if_b.sd_rd), 0);
      chk("save_loading", 32'(loading_b), 0);
      for (int s = 0; s < 4; s++) serve(1'b1, 32'(s), s, 3, 1'b0);
      chk("save_done_pulse", 32'(done_b), 1);
      step();
      chk("save_busy_after", 32'(busy_b), 0);
      chk("save_done_count", done_cnt_b, 1);
      save_req = 1'b0; enable_b = 1'b0;
      step();

      // Simultaneous load+save: load wins; mid-transfer save edge is ignored
      clear_counts();
      slot = 2'd3; enable_a = 1'b1; load_req = 1'b1; save_req = 1'b1;
      step();
      chk("both_rd", 32'(if_a.sd_rd), 1);
      chk("both_no_wr", 32'(if_a.sd_wr), 0);
      save_req = 1'b0;
      for (int s = 0; s < 64; s++) begin
         save_req = (s == 10);
         serve(1'b0, 32'(192 + s), s, 2, 1'b0);
      end
      save_req = 1'b0;
      reqs_a = 0;
      for (int i = 0; i < 10; i++) step();
      chk("both_no_extra_req", reqs_a, 0);
      chk("both_done_count", done_cnt_a, 1);
      chk("both_no_wr_total", wr_seen_a, 0);

      // enable low blocks a start
      enable_a = 1'b0; load_req = 1'b0;
      step();
      reqs_a = 0;
      load_req = 1'b1;
      step(); step(); step();
      chk("disabled_busy", 32'(busy_a), 0);
      chk("disabled_no_req", reqs_a, 0);

      // Abort during XFER of sector 5
      clear_counts();
      load_req = 1'b0; enable_a = 1'b1; slot = 2'd1;
      step();
      load_req = 1'b1;
      step();
      for (int s = 0; s < 5; s++) serve(1'b0, 32'(64 + s), s, 4, 1'b0);
      serve(1'b0, 32'(69), 5, 6, 1'b1);
      chk("abort_xfer_done", 32'(done_a), 1);
      chk("abort_xfer_busy", 32'(busy_a), 0);
      reqs_a = 0;
      for (int i = 0; i < 6; i++) step();
      chk("abort_xfer_no_req", reqs_a, 0);
      chk("abort_xfer_done_count", done_cnt_a, 1);

      // Abort in REQ before ack
      load_req = 1'b0; slot = 2'd0;
      step();
      load_req = 1'b1;
      step();
      chk("abort_req_rd_up", 32'(if_a.sd_rd), 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_req_rd_drop", 32'(if_a.sd_rd), 0);
      chk("abort_req_done", 32'(done_a), 1);
      chk("abort_req_busy", 32'(busy_a), 0);

      // Async reset during sector 10, then clean restart
      load_req = 1'b0; slot = 2'd2;
      step();
      load_req = 1'b1;
      step();
      for (int s = 0; s < 10; s++) serve(1'b0, 32'(128 + s), s, 2, 1'b0);
      if_a.sd_ack = 1'b1;
      step(); step();
      rst_n = 1'b0; load_req = 1'b0;
      #1;
      chk("arst_rd", 32'(if_a.sd_rd), 0);
      chk("arst_busy", 32'(busy_a), 0);
      chk("arst_loading", 32'(loading_a), 0);
      chk("arst_sect", 32'(sect_a), 0);
      chk("arst_lba", if_a.sd_lba, 0);
      step();
      rst_n = 1'b1;
      reqs_a = 0;
      step();
      if_a.sd_ack = 1'b0;
      step(); step();
      chk("arst_ignore_ack_busy", 32'(busy_a), 0);
      chk("arst_ignore_ack_req", reqs_a, 0);
      load_req = 1'b1;
      step();
      chk("restart_rd", 32'(if_a.sd_rd), 1);
      chk("restart_lba", if_a.sd_lba, 128);
      chk("restart_sect", 32'(sect_a), 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("restart_abort_done", 32'(done_a), 1);
      load_req = 1'b0; enable_a = 1'b0;
      step();

`ifdef BK_TIMEOUT_EN
      // Watchdog: no ack, 4-bit counter saturates 15 cycles after request
      clear_counts();
      enable_b = 1'b1; save_req = 1'b1;
      step();
      chk("tmo_wr_up", 32'(if_b.sd_wr), 1);
      t = 0;
      while (!done_b && t < 40) begin
         step();
         t++;
      end
      chk("tmo_latency", t, 15);
      chk("tmo_error", 32'(error_b), 1);
      chk("tmo_wr_drop", 32'(if_b.sd_wr), 0);
      chk("tmo_busy", 32'(busy_b), 0);
      save_req = 1'b0;
      step();
      chk("tmo_error_sticky", 32'(error_b), 1);
      save_req = 1'b1;
      step();
      chk("tmo_error_cleared", 32'(error_b), 0);
      save_req = 1'b0; abort = 1'b1;
      step();
      abort = 1'b0; enable_b = 1'b0;
      step();
`else
      t = 0;
      chk("no_tmo_error_a", 32'(error_a), 0);
      chk("no_tmo_error_b", 32'(error_b), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bk_sector_seq.md
Name: bk_sector_seq

Overview:
- Parametrised save-state sector sequencer between core state RAM and hps_io SD block interface.
- Load/save request transfers one slot of 2^SECT_BITS consecutive 512-byte sectors, slot selected by `slot`.
- Drives sd_lba/sd_rd/sd_wr; tracks the sd_ack handshake per sector.
- Exposes busy/loading for core reset gating and LED, plus a done pulse.
- Successor to the fixed 4-slot/64-sector inline logic: generalised slot count, slot size and LBA width, with defined priority and abort rules.

Parameters:
- SLOT_BITS, 2, width of slot select; 2^SLOT_BITS slots.
- SECT_BITS, 6, log2 sectors per slot (64 sectors = 32 KiB).
- LBA_W, 32, width of sd_lba.
- TIMEOUT_W, 24, width of ack watchdog counter (used only with BK_TIMEOUT_EN).

Ports:
- clk_sys  in  1  system clock
- RESET_n  in  1  asynchronous active-low reset
- enable  in  1  save file mounted and writable; gates requests
- load_req  in  1  level; rising edge of (load_req & enable) starts a load
- save_req  in  1  level; rising edge of (save_req & enable) starts a save
- abort  in  1  synchronous abort; finishes the current sector, then stops
- slot  in  SLOT_BITS  slot index, sampled at start
- sd_lba  out  LBA_W  current sector LBA
- sd_rd  out  1  read request to hps_io
- sd_wr  out  1  write request to hps_io
- sd_ack  in  1  hps_io ack; high while a sector is transferred
- busy  out  1  transfer in progress
- loading  out  1  busy and direction is load
- sect_idx  out  SECT_BITS  sector offset within slot; feeds state-RAM address high bits
- done  out  1  one-cycle pulse on completion or abort
- error  out  1  sticky timeout flag (0 when BK_TIMEOUT_EN is not defined)

Behaviour:
- Reset values: sd_lba=0, sd_rd=0, sd_wr=0, busy=0, loading=0, sect_idx=0, done=0, error=0. All internal edge registers and the FSM are cleared, with FSM in IDLE.
- Edge detect: ld_q <= load_req&enable; sv_q <= save_req&enable. A start is detected when (load_req&enable)&~ld_q, and likewise for save.
- States:
  - IDLE: on a start, go to REQ next cycle. Set busy=1, loading=(start was a load), sd_lba={slot, SECT_BITS'0} zero-extended to LBA_W, sect_idx=0.
  - Latency: the start edge sampled on cycle N gives sd_rd or sd_wr=1 on cycle N+1.
  - Load and save starting on the same cycle: load wins; the save edge is discarded.
  - Starts while busy are ignored, and their edges are consumed.
  - REQ: sd_rd=loading, sd_wr=~loading, held until sd_ack rising edge. Clear both on the cycle after the sd_ack rise is seen, then go to XFER.
  - XFER: wait for sd_ack falling edge.
    - If sect_idx == all-ones, or abort was seen since the sector started: pulse done, clear busy/loading, go to IDLE.
    - Otherwise sd_lba+1 and sect_idx+1 (sect_idx wraps only at the terminal sector, which ends the transfer), reassert the request, go to REQ.
- abort:
  - In IDLE: no effect.
  - In REQ before sd_ack: drop the request immediately, pulse done, go to IDLE.
  - In XFER: latched; takes effect at the sd_ack fall.
- sd_ack already high on entry to REQ: treated as no edge; wait for low then high.
- Async reset mid-transfer: all outputs return to reset values at once. hps_io may still complete the sector; the module ignores sd_ack until IDLE plus a fresh start.
- enable falling mid-transfer: the transfer continues.

Optional Feature:
- BK_TIMEOUT_EN defined: a TIMEOUT_W counter runs in REQ and XFER and clears on every sd_ack edge.
  - On saturation (all-ones): set error=1 (sticky until reset or the next start), drop sd_rd/sd_wr, pulse done, go to IDLE.
- Not defined: no counter. error is tied 0 and the FSM waits indefinitely.

Test Plan:
- Load, slot=2, default params, ack high 10 cycles per sector: sd_rd high on start+1; LBA sequence 128..191 (64 sectors); loading=1 throughout; single done after the 64th ack fall; sd_wr never high.
- Save, slot=0, SECT_BITS=2: sd_wr requests at LBA 0,1,2,3; sect_idx 0..3; done once; busy low on the cycle after done.
- load_req and save_req rise together, enable=1: load executes. A save_req pulse mid-transfer is ignored (no extra sectors after done). With enable=0, a rising load_req produces no request.
- abort:
  - Asserted during XFER of sector 5: sector 5 completes, no request for LBA base+6, done pulses.
  - Asserted in REQ before ack: request drops next cycle, done pulses.
- RESET_n low during sector 10: all outputs 0 asynchronously. A new load after reset restarts at LBA base+0.
- BK_TIMEOUT_EN, TIMEOUT_W=4, sd_ack never rises: error=1 and done pulse 15 cycles after the request asserts. The next start clears error.
